uart_word_rx: RTL
=================

UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Parameter TIMEOUT_BITS, default 20, idle bit-times after which a partial word is discarded.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rxd  input  1  asynchronous UART serial line; idle high; 8N1 format.
REQ-006 word_ack  input  1  consumer acknowledge; completes the word_valid handshake.
REQ-007 word_data  output  32  assembled word, byte 0 in [7:0], byte 3 in [31:24].
REQ-008 word_valid  output  1  word_data holds a complete word; held until acknowledged.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun  output  1  one-cycle pulse when a completed word is dropped because word_valid is still pending.
REQ-011 busy  output  1  high while the bit FSM is outside IDLE or a partial word is held.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer before use; all references to rxd below mean the synchronized value.
REQ-013 Bit FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START: rxd falls.
- START: at CLKS_PER_BIT/2 cycles, rxd low -> DATA; rxd high -> IDLE (glitch, no error).
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first -> STOP.
- STOP: sample after CLKS_PER_BIT cycles, then -> IDLE.
REQ-014 Stop bit = 1 SHALL store the byte at index byte_cnt (2 bits) and increment byte_cnt; byte_cnt wraps 3->0 on word completion.
REQ-015 Stop bit = 0 SHALL pulse frame_err, discard the byte, and clear byte_cnt and the partial word.
REQ-016 On the 4th good byte, word_data and word_valid SHALL update on the clock edge following the stop-bit sample (1-cycle latency).
REQ-017 word_valid SHALL remain high and word_data stable until a cycle with word_ack=1; word_valid clears on that edge.
REQ-018 word_ack while word_valid=0 SHALL be ignored.
REQ-019 Word completion while word_valid=1 and word_ack=0 SHALL pulse overrun and drop the new word; the old word is retained.
REQ-020 Word completion in the same cycle as word_ack SHALL load the new word and keep word_valid high, with no overrun.
REQ-021 With byte_cnt != 0 and the FSM in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles, byte_cnt SHALL clear and the partial word is discarded silently.
REQ-022 The timeout counter SHALL restart whenever the FSM leaves IDLE.
REQ-023 Reception SHALL continue while word_valid is pending; only completion is subject to REQ-019.

Reset
REQ-024 reset SHALL force:
- FSM = IDLE, byte_cnt = 0, all counters = 0;
- word_data = 0, word_valid = 0, frame_err = 0, overrun = 0, busy = 0;
- synchronizer flops = 1.
REQ-025 reset asserted mid-byte or mid-word SHALL abandon the byte/word; reception restarts only on a new falling edge after reset deasserts.

Structure
REQ-026 Package uart_pkg SHALL hold the bit-FSM state enum and default CLKS_PER_BIT; the existing UART transmitter shares it.
REQ-027 Sub-module uart_byte_rx SHALL implement REQ-012..REQ-015 bit timing (outputs: byte, byte_ok pulse, byte_err pulse).
REQ-028 uart_word_rx SHALL implement word assembly, handshake, and timeout around uart_byte_rx.

Verification (bench CLKS_PER_BIT=16, TIMEOUT_BITS=20)
REQ-029 Bytes 42,60,A5,3E sent back-to-back, word_ack low -> word_data=32'h3EA56042, word_valid=1 one cycle after the 4th stop sample; held until word_ack.
REQ-030 rxd low for 5 clocks, then high -> no byte, no frame_err, FSM returns to IDLE, busy=0.
REQ-031 Byte 3F with stop bit 0, then 00,00,80,3F -> single frame_err pulse; word_data=32'h3F800000.
REQ-032 Two full words 32'h3F000000 then 32'h3FF624DD, no word_ack -> overrun pulse; word_data stays 32'h3F000000.
REQ-033 Two bytes, idle 20*16 clocks, then 4 bytes DD,24,F6,3F -> word_data=32'h3FF624DD; no error pulses.
REQ-034 reset pulsed during the 2nd byte of a word, then a full word 32'h3EA56042 -> only 32'h3EA56042 is delivered, with all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-level receive state encoding and default baud timing.
// The UART transmitter imports this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizes rxd, detects a start edge, samples mid-bit,
// and reports each frame as a one-cycle byte_ok or byte_err pulse.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data_byte,
    output logic       byte_ok,
    output logic       byte_err,
    output logic       idle
);

    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

    rx_state_t   state;
    rx_state_t   next_state;
    logic [1:0]  sync;
    logic        rxd_s;
    logic        rxd_prev;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        half_hit;
    logic        full_hit;
    logic        fall;

    assign rxd_s    = sync[1];
    assign half_hit = (clk_cnt == HALF_M1);
    assign full_hit = (clk_cnt == FULL_M1);
    // A start needs a real high-to-low edge, so a line stuck low after a bad stop bit is ignored
    assign fall     = rxd_prev & ~rxd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            sync     <= {sync[0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (fall) next_state = START;
            START: if (half_hit) next_state = rxd_s ? IDLE : DATA;
            DATA:  if (full_hit && bit_idx == 3'd7) next_state = STOP;
            STOP:  if (full_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
                START: clk_cnt <= half_hit ? 16'd0 : clk_cnt + 16'd1;
                DATA: begin
                    if (full_hit) begin
                        clk_cnt <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: clk_cnt <= full_hit ? 16'd0 : clk_cnt + 16'd1;
                default: clk_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        byte_ok   = 1'b0;
        byte_err  = 1'b0;
        idle      = (state == IDLE);
        data_byte = shift;
        if (state == STOP && full_hit) begin
            byte_ok  = rxd_s;
            byte_err = ~rxd_s;
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// Assembles four received bytes (little-endian) into a 32-bit word with a
// valid/ack handshake, overrun detection and an idle timeout for partial words.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        word_ack,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic [7:0]  data_byte;
    logic        byte_ok;
    logic        byte_err;
    logic        idle;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [31:0] idle_cnt;
    logic        timeout_hit;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .data_byte(data_byte),
        .byte_ok  (byte_ok),
        .byte_err (byte_err),
        .idle     (idle)
    );

    assign busy        = ~idle | (byte_cnt != 2'd0);
    assign timeout_hit = idle && (byte_cnt != 2'd0) && (idle_cnt == TIMEOUT_M1);

    // Counts only while a partial word sits in IDLE; any frame activity restarts it
    always_ff @(posedge clk) begin
        if (reset || !idle || byte_cnt == 2'd0 || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            partial    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (word_ack && word_valid) begin
                word_valid <= 1'b0;
            end
            if (byte_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
                partial   <= '0;
            end else if (byte_ok) begin
                if (byte_cnt == 2'd3) begin
                    byte_cnt <= '0;
                    partial  <= '0;
                    // An ack in the same cycle frees the slot, so the new word wins
                    if (word_valid && !word_ack) begin
                        overrun <= 1'b1;
                    end else begin
                        word_data  <= {data_byte, partial};
                        word_valid <= 1'b1;
                    end
                end else begin
                    case (byte_cnt)
                        2'd0:    partial[7:0]   <= data_byte;
                        2'd1:    partial[15:8]  <= data_byte;
                        default: partial[23:16] <= data_byte;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else if (timeout_hit) begin
                byte_cnt <= '0;
                partial  <= '0;
            end
        end
    end

endmodule
